// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the external 1Mx16 asynchronous SRAM.
// It answers active-low CE/OE/WE/UB/LB strobes with a 1-cycle registered read.
// Optional byte-serial program loader, compiled in when the macro
// SRAM_RESPONDER_LOADER_EN is defined. Without it the loader ports are
// inert and the CPU bus is always live.
module sram_responder #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ce_ni,
    input  logic                  oe_ni,
    input  logic                  we_ni,
    input  logic                  ub_ni,
    input  logic                  lb_ni,
    input  logic [19:0]           addr_i,
    inout  wire  [15:0]           data_io,
    output logic                  drive_o,
    input  logic                  load_mode_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_data_i,
    output logic                  load_ready_o,
    output logic [DEPTH_LOG2:0]   load_count_o,
    output logic                  busy_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem_q [DEPTH];
    logic [15:0]           rd_q;
    logic                  drive_q;

    logic [DEPTH_LOG2-1:0] cpu_addr;
    logic                  bus_en;
    logic                  cpu_wr;
    logic                  cpu_rd;

    logic [1:0]            wr_be;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [15:0]           wr_data;

    // Upper address bits alias onto the implemented depth.
    assign cpu_addr = addr_i[DEPTH_LOG2-1:0];

    // A write (CE=0, WE=0) wins over OE; a read needs WE high and OE low.
    assign cpu_wr = bus_en & ~ce_ni & ~we_ni;
    assign cpu_rd = bus_en & ~ce_ni & we_ni & ~oe_ni;

`ifdef SRAM_RESPONDER_LOADER_EN
    typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO} state_t;

    localparam logic [DEPTH_LOG2:0] COUNT_MAX = (DEPTH_LOG2+1)'(DEPTH);

    state_t                state_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic [7:0]            hi_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  loader_wr;

    // The CPU only sees memory once the loader is idle and released.
    assign bus_en    = (state_q == ST_IDLE) & ~load_mode_i;
    assign loader_wr = (state_q == ST_LO) & load_mode_i & load_valid_i;

    // Loader FSM: high byte then low byte per word; dropping Load_mode aborts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hi_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_mode_i) begin
                        state_q <= ST_HI;
                        ptr_q   <= '0;
                        count_q <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_HI: begin
                    if (!load_mode_i) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (load_valid_i) begin
                        hi_q    <= load_data_i;
                        state_q <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (!load_mode_i) begin
                        // Pending high byte is simply dropped.
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (load_valid_i) begin
                        ptr_q   <= ptr_q + 1'b1;
                        if (count_q != COUNT_MAX) begin
                            count_q <= count_q + 1'b1;
                        end
                        state_q <= ST_HI;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign load_count_o = count_q;

    // Single write port shared by loader (full word) and CPU (byte lanes).
    always_comb begin
        wr_be   = 2'b00;
        wr_addr = cpu_addr;
        wr_data = data_io;
        if (loader_wr) begin
            wr_be   = 2'b11;
            wr_addr = ptr_q;
            wr_data = {hi_q, load_data_i};
        end else if (cpu_wr) begin
            wr_be   = {~ub_ni, ~lb_ni};
        end
    end
`else
    logic unused_loader;

    assign bus_en        = 1'b1;
    assign load_ready_o  = 1'b0;
    assign busy_o        = 1'b0;
    assign load_count_o  = '0;
    assign unused_loader = ^{load_mode_i, load_valid_i, load_data_i};

    // CPU is the only writer; byte lanes select the halves.
    always_comb begin
        wr_be   = 2'b00;
        wr_addr = cpu_addr;
        wr_data = data_io;
        if (cpu_wr) begin
            wr_be = {~ub_ni, ~lb_ni};
        end
    end
`endif

    // Memory array: byte-lane write, no reset so contents survive Reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // Registered read data and bus drive enable, one cycle behind the strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            drive_q <= 1'b0;
        end else begin
            drive_q <= cpu_rd;
            if (cpu_rd) begin
                rd_q <= mem_q[cpu_addr];
            end
        end
    end

    logic unused_addr;
    assign unused_addr = ^addr_i[19:DEPTH_LOG2];

    assign drive_o = drive_q;
    assign data_io = drive_q ? rd_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_responder.sv
// Directed testbench for sram_responder: CPU bus reads/writes, byte lanes,
// write-over-read priority, aliasing and (when SRAM_RESPONDER_LOADER_EN is
// defined) the byte-serial loader, its abort on reset and count saturation.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;
    logic [19:0] addr;
    wire  [15:0] data_w;
    logic [15:0] tb_data;
    logic        tb_oe;
    logic        drive;
    logic        load_mode, load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic [10:0] load_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    assign data_w = tb_oe ? tb_data : 16'hzzzz;

    always #5 clk = ~clk;

    sram_responder #(.DEPTH_LOG2(10)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ce_ni        (ce_n),
        .oe_ni        (oe_n),
        .we_ni        (we_n),
        .ub_ni        (ub_n),
        .lb_ni        (lb_n),
        .addr_i       (addr),
        .data_io      (data_w),
        .drive_o      (drive),
        .load_mode_i  (load_mode),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_ready_o (load_ready),
        .load_count_o (load_count),
        .busy_o       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        tb_oe = 1'b0;
    endtask

    task automatic cpu_write(input logic [19:0] a, input logic [15:0] d,
                             input logic u, input logic l);
        addr = a; tb_data = d; tb_oe = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = u; lb_n = l;
        step();
        bus_idle();
    endtask

    // Present a read and let one edge pass; data is then on the bus.
    task automatic cpu_read_start(input logic [19:0] a);
        tb_oe = 1'b0; addr = a;
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
        step();
    endtask

    // Release strobes and wait for the responder to let go of the bus.
    task automatic cpu_read_end();
        bus_idle();
        step();
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_data = b; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        addr = '0; tb_data = '0;
        load_mode = 1'b0; load_valid = 1'b0; load_data = '0;
        step(); step();
        checks++; if (drive !== 1'b0) begin errors++; $display("FAIL reset_drive: got %b want 0", drive); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", load_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (load_count !== 11'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", load_count); end
        rst_n = 1'b1;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_byte_lanes();
        cpu_write(20'd5, 16'h0000, 1'b0, 1'b0);
        cpu_write(20'd5, 16'hBEEF, 1'b0, 1'b1);
        cpu_read_start(20'd5);
        checks++; if (drive !== 1'b1) begin errors++; $display("FAIL read_drive: got %b want 1", drive); end
        checks++; if (data_w !== 16'hBE00) begin errors++; $display("FAIL ub_write: got %h want be00", data_w); end
        cpu_read_end();
        cpu_write(20'd5, 16'h00CD, 1'b1, 1'b0);
        cpu_read_start(20'd5);
        checks++; if (data_w !== 16'hBECD) begin errors++; $display("FAIL lb_write: got %h want becd", data_w); end
        cpu_read_end();
        cpu_write(20'd5, 16'h7777, 1'b1, 1'b1);
        cpu_read_start(20'd5);
        checks++; if (data_w !== 16'hBECD) begin errors++; $display("FAIL no_lane_write: got %h want becd", data_w); end
        cpu_read_end();
        $display("test_byte_lanes: done");
    endtask

    task automatic test_write_priority();
        addr = 20'd7; tb_data = 16'h1111; tb_oe = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
        step();
        checks++; if (drive !== 1'b0) begin errors++; $display("FAIL wr_prio_drive: got %b want 0", drive); end
        bus_idle();
        cpu_read_start(20'd7);
        checks++; if (data_w !== 16'h1111) begin errors++; $display("FAIL wr_prio_data: got %h want 1111", data_w); end
        cpu_read_end();
        $display("test_write_priority: done");
    endtask

    task automatic test_read_tracking();
        cpu_read_start(20'd5);
        addr = 20'd7;
        checks++; if (data_w !== 16'hBECD) begin errors++; $display("FAIL track_lag: got %h want becd", data_w); end
        step();
        checks++; if (data_w !== 16'h1111) begin errors++; $display("FAIL track_next: got %h want 1111", data_w); end
        oe_n = 1'b1;
        checks++; if (drive !== 1'b1) begin errors++; $display("FAIL drive_hold: got %b want 1", drive); end
        step();
        checks++; if (drive !== 1'b0) begin errors++; $display("FAIL drive_release: got %b want 0", drive); end
        bus_idle();
        $display("test_read_tracking: done");
    endtask

    task automatic test_alias();
        cpu_write(20'h00405, 16'h5A5A, 1'b0, 1'b0);
        cpu_read_start(20'd5);
        checks++; if (data_w !== 16'h5A5A) begin errors++; $display("FAIL alias_low: got %h want 5a5a", data_w); end
        cpu_read_end();
        cpu_read_start(20'hFFC05);
        checks++; if (data_w !== 16'h5A5A) begin errors++; $display("FAIL alias_high: got %h want 5a5a", data_w); end
        cpu_read_end();
        $display("test_alias: done");
    endtask

`ifdef SRAM_RESPONDER_LOADER_EN
    task automatic test_load();
        load_mode = 1'b1;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b want 0", load_ready); end
        step();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b want 1", load_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", busy); end
        load_byte(8'h12); load_byte(8'h34); load_byte(8'h56); load_byte(8'h78);
        checks++; if (load_count !== 11'd2) begin errors++; $display("FAIL load_count: got %0d want 2", load_count); end
        load_mode = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy); end
        checks++; if (load_count !== 11'd2) begin errors++; $display("FAIL count_hold: got %0d want 2", load_count); end
        cpu_read_start(20'd0);
        checks++; if (data_w !== 16'h1234) begin errors++; $display("FAIL load_word0: got %h want 1234", data_w); end
        addr = 20'd1;
        step();
        checks++; if (data_w !== 16'h5678) begin errors++; $display("FAIL load_word1: got %h want 5678", data_w); end
        cpu_read_end();
        $display("test_load: done");
    endtask

    task automatic test_load_blocks_cpu();
        cpu_write(20'd3, 16'h3333, 1'b0, 1'b0);
        load_mode = 1'b1;
        step();
        cpu_write(20'd3, 16'hFFFF, 1'b0, 1'b0);
        checks++; if (drive !== 1'b0) begin errors++; $display("FAIL blk_wr_drive: got %b want 0", drive); end
        cpu_read_start(20'd3);
        checks++; if (drive !== 1'b0) begin errors++; $display("FAIL blk_rd_drive: got %b want 0", drive); end
        bus_idle();
        load_mode = 1'b0;
        step();
        cpu_read_start(20'd3);
        checks++; if (data_w !== 16'h3333) begin errors++; $display("FAIL blk_word3: got %h want 3333", data_w); end
        cpu_read_end();
        $display("test_load_blocks_cpu: done");
    endtask

    task automatic test_reset_mid_lo();
        load_mode = 1'b1;
        step();
        load_byte(8'h99); load_byte(8'h99);
        load_byte(8'hAB);
        checks++; if (load_count !== 11'd1) begin errors++; $display("FAIL mid_pre_count: got %0d want 1", load_count); end
        load_data = 8'hCD; load_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (load_count !== 11'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", load_count); end
        checks++; if (drive !== 1'b0) begin errors++; $display("FAIL mid_drive: got %b want 0", drive); end
        step();
        load_valid = 1'b0; load_mode = 1'b0;
        rst_n = 1'b1;
        step();
        cpu_read_start(20'd1);
        checks++; if (data_w !== 16'h5678) begin errors++; $display("FAIL mid_target: got %h want 5678", data_w); end
        addr = 20'd0;
        step();
        checks++; if (data_w !== 16'h9999) begin errors++; $display("FAIL mid_kept: got %h want 9999", data_w); end
        cpu_read_end();
        $display("test_reset_mid_lo: done");
    endtask

    task automatic test_saturation();
        logic [15:0] w;
        load_mode = 1'b1;
        step();
        for (int i = 0; i < 1025; i++) begin
            w = 16'hC000 | 16'(i);
            load_byte(w[15:8]);
            load_byte(w[7:0]);
            if (i == 1023) begin
                checks++; if (load_count !== 11'd1024) begin errors++; $display("FAIL sat_full: got %0d want 1024", load_count); end
            end
        end
        checks++; if (load_count !== 11'd1024) begin errors++; $display("FAIL sat_hold: got %0d want 1024", load_count); end
        load_mode = 1'b0;
        step();
        cpu_read_start(20'd0);
        checks++; if (data_w !== 16'hC400) begin errors++; $display("FAIL sat_word0: got %h want c400", data_w); end
        addr = 20'd1;
        step();
        checks++; if (data_w !== 16'hC001) begin errors++; $display("FAIL sat_word1: got %h want c001", data_w); end
        addr = 20'h003FF;
        step();
        checks++; if (data_w !== 16'hC3FF) begin errors++; $display("FAIL sat_word3ff: got %h want c3ff", data_w); end
        cpu_read_end();
        $display("test_saturation: done");
    endtask
`else
    task automatic test_no_loader();
        load_mode = 1'b1; load_valid = 1'b1; load_data = 8'hA5;
        step(); step();
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL nl_ready: got %b want 0", load_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nl_busy: got %b want 0", busy); end
        checks++; if (load_count !== 11'd0) begin errors++; $display("FAIL nl_count: got %0d want 0", load_count); end
        cpu_write(20'd9, 16'h4242, 1'b0, 1'b0);
        cpu_read_start(20'd9);
        checks++; if (drive !== 1'b1) begin errors++; $display("FAIL nl_drive: got %b want 1", drive); end
        checks++; if (data_w !== 16'h4242) begin errors++; $display("FAIL nl_data: got %h want 4242", data_w); end
        cpu_read_end();
        load_mode = 1'b0; load_valid = 1'b0;
        $display("test_no_loader: done");
    endtask
`endif

    initial begin
        test_reset();
        test_byte_lanes();
        test_write_priority();
        test_read_tracking();
        test_alias();
`ifdef SRAM_RESPONDER_LOADER_EN
        test_load();
        test_load_blocks_cpu();
        test_reset_mid_lo();
        test_saturation();
`else
        test_no_loader();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
